// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 read path.
// Holds the controller state encoding, the err_code values, the default
// cycle constants for a 5.12 us tick (also used by the bit receiver), and
// the mod-256 checksum helper.
package dht11_pkg;

    localparam int TICK_NS              = 5120;  // 195.3125 kHz tick period
    localparam int DEF_START_LOW_CYCLES = 3516;  // 18 ms host start pulse
    localparam int DEF_RESP_TIMEOUT     = 40;    // ~205 us per response phase
    localparam int DEF_FRAME_TIMEOUT    = 1200;  // ~6.1 ms for all 40 bits
    localparam int DEF_CNT_W            = 12;
    localparam int FRAME_BITS           = 40;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_LOW,
        S_WAIT_RESP_LOW,
        S_WAIT_RESP_HIGH,
        S_WAIT_RESP_END,
        S_RECEIVE,
        S_CHECK
    } state_t;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_NO_RESP  = 2'b01;
    localparam logic [1:0] ERR_BIT      = 2'b10;
    localparam logic [1:0] ERR_CHECKSUM = 2'b11;

    // Sum of the four data bytes, truncated to 8 bits (mod 256).
    function automatic logic [7:0] checksum8(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c, input logic [7:0] d);
        return a + b + c + d;
    endfunction

endpackage

// File: rtl/dht11_if.sv
// Signal bundle between the DHT11 controller and its surroundings.
// Requester side : start, busy, done, error, err_code, hum/temp readings.
// Bus side       : dht11_data_s (synchronized level), dht_oe (pull low).
// Receiver side  : rx_en, bit_valid, bit_value, bit_err.
// state          : controller FSM state, exported for observation.
// Handshake: start is a level sampled only while the controller is idle;
// done is a one-cycle pulse and error/err_code/readings are valid with it;
// bit_valid and bit_err are one-cycle strobes from the receiver.
// master = controller view, slave = requester/receiver/bus view.
interface dht11_if;
    import dht11_pkg::*;

    logic       start;
    logic       dht11_data_s;
    logic       dht_oe;
    logic       rx_en;
    logic       bit_valid;
    logic       bit_value;
    logic       bit_err;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;
    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] temp_int;
    logic [7:0] temp_dec;
    state_t     state;

    modport master (
        input  start, dht11_data_s, bit_valid, bit_value, bit_err,
        output dht_oe, rx_en, busy, done, error, err_code,
               hum_int, hum_dec, temp_int, temp_dec, state
    );

    modport slave (
        output start, dht11_data_s, bit_valid, bit_value, bit_err,
        input  dht_oe, rx_en, busy, done, error, err_code,
               hum_int, hum_dec, temp_int, temp_dec, state
    );

endinterface

// File: rtl/dht11_frame_check.sv
// Splits a received 40-bit DHT11 frame into its bytes and checks the sum.
// Ports: frame (first received bit in bit 39), the four data bytes, and
// ok = 1 when (B4+B3+B2+B1) mod 256 equals the final byte B0.
module dht11_frame_check
    import dht11_pkg::*;
(
    input  logic [FRAME_BITS-1:0] frame,
    output logic [7:0]            hum_int,
    output logic [7:0]            hum_dec,
    output logic [7:0]            temp_int,
    output logic [7:0]            temp_dec,
    output logic                  ok
);

    assign hum_int  = frame[39:32];
    assign hum_dec  = frame[31:24];
    assign temp_int = frame[23:16];
    assign temp_dec = frame[15:8];
    assign ok       = (checksum8(hum_int, hum_dec, temp_int, temp_dec) == frame[7:0]);

endmodule

// File: rtl/dht11_controller.sv
// Sequencer for one DHT11 read transaction: host start pulse, sensor
// response check, 40-bit frame assembly, checksum and result publication.
// Ports: clk, rst (async, active high), ctl (dht11_if.master, see the
// interface file for the signal list).
// All outputs are registered; dht_oe is cleared by the async reset so the
// bus is released the moment rst rises.
module dht11_controller
    import dht11_pkg::*;
#(
    parameter int START_LOW_CYCLES = DEF_START_LOW_CYCLES,
    parameter int RESP_TIMEOUT     = DEF_RESP_TIMEOUT,
    parameter int FRAME_TIMEOUT    = DEF_FRAME_TIMEOUT,
    parameter int CNT_W            = DEF_CNT_W
)(
    input logic    clk,
    input logic    rst,
    dht11_if.master ctl
);

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESP_LAST  = CNT_W'(RESP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TIMEOUT - 1);

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt;
    logic [5:0]            bit_idx;
    logic [FRAME_BITS-1:0] frame;
    logic                  dht_oe_q, rx_en_q, busy_q, done_q, error_q;
    logic [1:0]            code_q, code_n;
    logic                  done_n, error_n, load_n, abort;
    logic [7:0]            hum_int_q, hum_dec_q, temp_int_q, temp_dec_q;
    logic [7:0]            f_hum_int, f_hum_dec, f_temp_int, f_temp_dec;
    logic                  f_ok;

    dht11_frame_check u_check (
        .frame    (frame),
        .hum_int  (f_hum_int),
        .hum_dec  (f_hum_dec),
        .temp_int (f_temp_int),
        .temp_dec (f_temp_dec),
        .ok       (f_ok)
    );

    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        error_n = 1'b0;
        load_n  = 1'b0;
        code_n  = ERR_OK;
        abort   = 1'b0;
        case (state)
            S_IDLE:
                if (ctl.start) state_n = S_START_LOW;
            S_START_LOW:
                if (cnt == START_LAST) state_n = S_WAIT_RESP_LOW;
            S_WAIT_RESP_LOW:
                if (!ctl.dht11_data_s)   state_n = S_WAIT_RESP_HIGH;
                else if (cnt == RESP_LAST) begin abort = 1'b1; code_n = ERR_NO_RESP; end
            S_WAIT_RESP_HIGH:
                if (ctl.dht11_data_s)    state_n = S_WAIT_RESP_END;
                else if (cnt == RESP_LAST) begin abort = 1'b1; code_n = ERR_NO_RESP; end
            S_WAIT_RESP_END:
                if (!ctl.dht11_data_s)   state_n = S_RECEIVE;
                else if (cnt == RESP_LAST) begin abort = 1'b1; code_n = ERR_NO_RESP; end
            S_RECEIVE:
                // Priority: receiver error, then a decoded bit, then timeout.
                if (ctl.bit_err) begin
                    abort  = 1'b1;
                    code_n = ERR_BIT;
                end else if (ctl.bit_valid) begin
                    if (bit_idx == 6'd39) state_n = S_CHECK;
                end else if (cnt == FRAME_LAST) begin
                    abort  = 1'b1;
                    code_n = ERR_BIT;
                end
            S_CHECK: begin
                state_n = S_IDLE;
                done_n  = 1'b1;
                if (f_ok) begin
                    load_n = 1'b1;
                    code_n = ERR_OK;
                end else begin
                    error_n = 1'b1;
                    code_n  = ERR_CHECKSUM;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (abort) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
            error_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            frame      <= '0;
            dht_oe_q   <= 1'b0;
            rx_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            code_q     <= ERR_OK;
            hum_int_q  <= '0;
            hum_dec_q  <= '0;
            temp_int_q <= '0;
            temp_dec_q <= '0;
        end else begin
            state <= state_n;
            // One shared counter, restarted on every state change.
            cnt      <= (state_n != state) ? '0 : cnt + CNT_W'(1);
            // Outputs follow the next state so they line up with it.
            dht_oe_q <= (state_n == S_START_LOW);
            rx_en_q  <= (state_n == S_RECEIVE);
            busy_q   <= (state_n != S_IDLE);
            done_q   <= done_n;
            error_q  <= error_n;
            if (done_n) code_q <= code_n;
            if (load_n) begin
                hum_int_q  <= f_hum_int;
                hum_dec_q  <= f_hum_dec;
                temp_int_q <= f_temp_int;
                temp_dec_q <= f_temp_dec;
            end
            if (state != S_RECEIVE) begin
                bit_idx <= '0;
            end else if (ctl.bit_valid && !ctl.bit_err) begin
                frame   <= {frame[FRAME_BITS-2:0], ctl.bit_value};
                bit_idx <= bit_idx + 6'd1;
            end
        end
    end

    assign ctl.dht_oe   = dht_oe_q;
    assign ctl.rx_en    = rx_en_q;
    assign ctl.busy     = busy_q;
    assign ctl.done     = done_q;
    assign ctl.error    = error_q;
    assign ctl.err_code = code_q;
    assign ctl.hum_int  = hum_int_q;
    assign ctl.hum_dec  = hum_dec_q;
    assign ctl.temp_int = temp_int_q;
    assign ctl.temp_dec = temp_dec_q;
    assign ctl.state    = state;

endmodule

// File: tb/tb_dht11_controller.sv
// Bench for dht11_controller. Each transaction is described by its kind and
// frame; from that the bench derives, with plain cycle arithmetic, the
// windows in which dht_oe / busy / rx_en must be high, the done cycle and
// the result that must be published. A negedge process compares every
// cycle's outputs against those windows.
module tb_dht11_controller;

    localparam int N = 3516;     // host low-pulse length in cycles
    localparam int K_FRAME   = 0;
    localparam int K_NO_RESP = 1;
    localparam int K_BIT_ERR = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dht11_if bus_if();

    dht11_controller dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- model state ----------------
    int oe_lo = 1, oe_hi = 0, busy_lo = 1, busy_hi = 0, rx_lo = 1, rx_hi = 0;
    int done_at = -1;
    logic       pend_err  = 1'b0;
    logic       pend_load = 1'b0;
    logic [1:0] pend_code = 2'b00;
    logic [7:0] pend_d [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] exp_d  [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
    logic [1:0] exp_code = 2'b00;

    // observations used by the hand-computed literal checks
    int oe_run = 0, oe_len = 0, busy_rise = -1, done_cyc = -1;
    logic busy_prev = 1'b0;
    logic rx_seen = 1'b0;

    function automatic logic in_win(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    always @(negedge clk) begin
        logic [38:0] act, req;
        logic in_done;
        in_done = (cyc == done_at);
        if (in_done) begin
            exp_code = pend_code;
            if (pend_load) exp_d = pend_d;
        end
        req = {in_win(cyc, oe_lo, oe_hi), in_win(cyc, busy_lo, busy_hi),
               in_win(cyc, rx_lo, rx_hi), in_done, in_done & pend_err, exp_code,
               exp_d[0], exp_d[1], exp_d[2], exp_d[3]};
        act = {bus_if.dht_oe, bus_if.busy, bus_if.rx_en, bus_if.done, bus_if.error,
               bus_if.err_code, bus_if.hum_int, bus_if.hum_dec, bus_if.temp_int,
               bus_if.temp_dec};
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            if (n_bad <= 20)
                $display("FAIL outputs cycle %0d: actual oe/busy/rx/done/err/code/data=%h required=%h",
                         cyc, act, req);
        end
        if (bus_if.dht_oe) oe_run++;
        else if (oe_run != 0) begin oe_len = oe_run; oe_run = 0; end
        if (bus_if.busy && !busy_prev) busy_rise = cyc;
        busy_prev = bus_if.busy;
        if (bus_if.done) done_cyc = cyc;
        if (bus_if.rx_en) rx_seen = 1'b1;
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Returns at the negedge inside cycle t (t must lie in the future).
    task automatic goto(input int t);
        @(negedge clk);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic run_txn(input int kind, input logic [39:0] fr, input logic extra_start);
        int c, s, w, r, t_last;
        logic [7:0] b4, b3, b2, b1, b0;
        logic good;
        @(negedge clk);
        c = cyc;
        s = c + 1;           // first busy / dht_oe cycle
        w = s + N;           // first WAIT_RESP_LOW cycle
        r = w + 17;          // first RECEIVE cycle for the response driven below
        b4 = fr[39:32]; b3 = fr[31:24]; b2 = fr[23:16]; b1 = fr[15:8]; b0 = fr[7:0];
        good = (((int'(b4) + int'(b3) + int'(b2) + int'(b1)) % 256) == int'(b0));
        oe_lo = s; oe_hi = s + N - 1; busy_lo = s;
        rx_seen = 1'b0;
        if (kind == K_NO_RESP) begin
            busy_hi = w + 39; rx_lo = 1; rx_hi = 0; done_at = w + 40;
            pend_err = 1'b1; pend_code = 2'b01; pend_load = 1'b0;
        end else if (kind == K_BIT_ERR) begin
            t_last = r + 2 + 3 * 16;
            busy_hi = t_last; rx_lo = r; rx_hi = t_last; done_at = t_last + 1;
            pend_err = 1'b1; pend_code = 2'b10; pend_load = 1'b0;
        end else begin
            t_last = r + 2 + 3 * 39;
            busy_hi = t_last + 1; rx_lo = r; rx_hi = t_last; done_at = t_last + 2;
            pend_err = !good; pend_code = good ? 2'b00 : 2'b11; pend_load = good;
            pend_d = '{b4, b3, b2, b1};
        end
        bus_if.start = 1'b1;
        goto(c + 1);
        bus_if.start = 1'b0;
        if (extra_start) begin
            goto(s + 100); bus_if.start = 1'b1;
            goto(s + 101); bus_if.start = 1'b0;
        end
        if (kind != K_NO_RESP) begin
            goto(w + 3);  bus_if.dht11_data_s = 1'b0;
            goto(w + 9);  bus_if.dht11_data_s = 1'b1;
            goto(w + 16); bus_if.dht11_data_s = 1'b0;
            for (int i = 0; i < 40; i++) begin
                goto(r + 2 + 3 * i);
                bus_if.bit_valid = 1'b1;
                bus_if.bit_value = fr[39 - i];
                bus_if.bit_err   = (kind == K_BIT_ERR) && (i == 16);
                goto(r + 3 + 3 * i);
                bus_if.bit_valid = 1'b0;
                bus_if.bit_value = 1'b0;
                bus_if.bit_err   = 1'b0;
                if ((kind == K_BIT_ERR) && (i == 16)) break;
            end
        end
        goto(done_at + 1);
        bus_if.dht11_data_s = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, s;
        bus_if.start = 1'b0;
        bus_if.dht11_data_s = 1'b1;
        bus_if.bit_valid = 1'b0;
        bus_if.bit_value = 1'b0;
        bus_if.bit_err = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_dht_oe", int'(bus_if.dht_oe), 0);
        check("reset_busy", int'(bus_if.busy), 0);
        check("reset_err_code", int'(bus_if.err_code), 0);
        check("reset_hum_int", int'(bus_if.hum_int), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Good frame
        run_txn(K_FRAME, 40'h28_00_1A_05_47, 1'b0);
        check("good_oe_len", oe_len, 3516);
        check("good_hum_int", int'(bus_if.hum_int), 40);
        check("good_hum_dec", int'(bus_if.hum_dec), 0);
        check("good_temp_int", int'(bus_if.temp_int), 26);
        check("good_temp_dec", int'(bus_if.temp_dec), 5);
        check("good_err_code", int'(bus_if.err_code), 0);

        // Good frame whose byte sum wraps past 255 (0x15F -> 0x5F)
        run_txn(K_FRAME, 40'hFF_10_20_30_5F, 1'b0);
        check("wrap_hum_int", int'(bus_if.hum_int), 255);
        check("wrap_temp_dec", int'(bus_if.temp_dec), 48);

        // Bad checksum: readings keep the previous values
        run_txn(K_FRAME, 40'h28_00_1A_05_48, 1'b0);
        check("csum_err_code", int'(bus_if.err_code), 3);
        check("csum_hum_int_held", int'(bus_if.hum_int), 255);

        // No response, with an ignored start during START_LOW
        run_txn(K_NO_RESP, 40'h0, 1'b1);
        check("noresp_latency", done_cyc - busy_rise, 3556);
        check("noresp_rx_never", int'(rx_seen), 0);
        check("noresp_err_code", int'(bus_if.err_code), 1);
        check("noresp_oe_len", oe_len, 3516);

        // Bit error on the 17th bit together with bit_valid
        run_txn(K_BIT_ERR, 40'h28_00_1A_05_47, 1'b0);
        check("biterr_err_code", int'(bus_if.err_code), 2);
        check("biterr_hum_int_held", int'(bus_if.hum_int), 255);

        // Reset in the middle of START_LOW
        @(negedge clk);
        c = cyc; s = c + 1;
        oe_lo = s; oe_hi = s + N - 1; busy_lo = s; busy_hi = s + N + 39;
        rx_lo = 1; rx_hi = 0; done_at = s + N + 40;
        pend_err = 1'b1; pend_code = 2'b01; pend_load = 1'b0;
        bus_if.start = 1'b1;
        goto(c + 1);
        bus_if.start = 1'b0;
        goto(s + 200);
        check("pre_rst_dht_oe", int'(bus_if.dht_oe), 1);
        #2;
        rst = 1'b1;
        oe_hi = s + 200; busy_hi = s + 200; done_at = -1;
        exp_d = '{8'd0, 8'd0, 8'd0, 8'd0};
        exp_code = 2'b00;
        #1;
        check("rst_dht_oe_async", int'(bus_if.dht_oe), 0);
        check("rst_busy_async", int'(bus_if.busy), 0);
        goto(s + 203);
        rst = 1'b0;
        goto(s + 230);
        check("post_rst_done_cnt", done_cyc, done_cyc < s ? done_cyc : -1);
        check("post_rst_hum_int", int'(bus_if.hum_int), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
